// File: rtl/wb_regfile.sv
// Writeback stage: selects the retiring value, updates the 16x16 register file,
// serves two bypassed read ports, and tracks halt retirement and instruction count.
module wb_regfile #(
    parameter int NREG = 16,
    parameter int DW   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    RegWrite,
    input  logic                    MemtoReg,
    input  logic                    PCS,
    input  logic                    HALT,
    input  logic [DW-1:0]           ALU_Out,
    input  logic [DW-1:0]           DataMem,
    input  logic [DW-1:0]           PC_Inc,
    input  logic [$clog2(NREG)-1:0] Rd,
    input  logic [$clog2(NREG)-1:0] SrcReg1,
    input  logic [$clog2(NREG)-1:0] SrcReg2,
    output logic [DW-1:0]           SrcData1,
    output logic [DW-1:0]           SrcData2,
    output logic [DW-1:0]           WB_Data,
    output logic                    WB_En,
    output logic                    Halted,
    output logic [15:0]             Retired
);

    logic [DW-1:0] regs [NREG];
    logic          halted_q;
    logic [15:0]   retired_q;
    logic          valid_instr;

    // PC+2 (link) wins over load data, which wins over the ALU result
    always_comb begin
        WB_Data = '0;
        if (PCS) begin
            WB_Data = PC_Inc;
        end else if (MemtoReg) begin
            WB_Data = DataMem;
        end else begin
            WB_Data = ALU_Out;
        end
    end

    assign valid_instr = RegWrite | MemtoReg | PCS | HALT;

    // A retiring HALT never writes, and nothing writes once halted or into R0
    assign WB_En = RegWrite & ~HALT & ~halted_q & (Rd != '0);

    always_comb begin
        SrcData1 = '0;
        if (SrcReg1 != '0) begin
            if (WB_En && (SrcReg1 == Rd)) begin
                SrcData1 = WB_Data;
            end else begin
                SrcData1 = regs[SrcReg1];
            end
        end
    end

    always_comb begin
        SrcData2 = '0;
        if (SrcReg2 != '0) begin
            if (WB_En && (SrcReg2 == Rd)) begin
                SrcData2 = WB_Data;
            end else begin
                SrcData2 = regs[SrcReg2];
            end
        end
    end

    // Reset takes priority so a write presented in the reset cycle is dropped
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (WB_En) begin
            regs[Rd] <= WB_Data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            halted_q <= 1'b0;
        end else if (HALT && !halted_q) begin
            halted_q <= 1'b1;
        end
    end

    // The HALT cycle itself still counts; the counter wraps freely
    always_ff @(posedge clk) begin
        if (rst_n) begin
            retired_q <= '0;
        end else if (!halted_q && valid_instr) begin
            retired_q <= retired_q + 16'd1;
        end
    end

    assign Halted  = halted_q;
    assign Retired = retired_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Testbench for wb_regfile: directed vector table, Retired wrap sequence,
// then randomized traffic against an array-based reference model.
module tb_wb_regfile;

    typedef struct {
        logic        rst, rw, m2r, pcs, halt;
        logic [15:0] alu, dmem, pcinc;
        logic [3:0]  rd, s1, s2;
        logic [15:0] e_s1, e_s2, e_wb;
        logic        e_en, e_halted;
        logic [15:0] e_ret;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, RegWrite, MemtoReg, PCS, HALT;
    logic [15:0] ALU_Out, DataMem, PC_Inc;
    logic [3:0]  Rd, SrcReg1, SrcReg2;
    logic [15:0] SrcData1, SrcData2, WB_Data, Retired;
    logic        WB_En, Halted;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] m_regs [16];
    logic        m_halted;
    int unsigned m_ret;

    vec_t vecs [14];

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .PCS(PCS), .HALT(HALT), .ALU_Out(ALU_Out), .DataMem(DataMem),
        .PC_Inc(PC_Inc), .Rd(Rd), .SrcReg1(SrcReg1), .SrcReg2(SrcReg2),
        .SrcData1(SrcData1), .SrcData2(SrcData2), .WB_Data(WB_Data),
        .WB_En(WB_En), .Halted(Halted), .Retired(Retired)
    );

    // Drive just after the falling edge, so outputs settle well before the next rising edge
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst_n    = v.rst;
        RegWrite = v.rw;
        MemtoReg = v.m2r;
        PCS      = v.pcs;
        HALT     = v.halt;
        ALU_Out  = v.alu;
        DataMem  = v.dmem;
        PC_Inc   = v.pcinc;
        Rd       = v.rd;
        SrcReg1  = v.s1;
        SrcReg2  = v.s2;
        #1;
    endtask

    task automatic cmp(input string nm, input string fld, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s.%s: got %h, expected %h", nm, fld, act, exp);
        end
    endtask

    task automatic checkOutput(input vec_t v, input string nm);
        cmp(nm, "SrcData1", SrcData1, v.e_s1);
        cmp(nm, "SrcData2", SrcData2, v.e_s2);
        cmp(nm, "WB_Data", WB_Data, v.e_wb);
        cmp(nm, "WB_En", {15'd0, WB_En}, {15'd0, v.e_en});
        cmp(nm, "Halted", {15'd0, Halted}, {15'd0, v.e_halted});
        cmp(nm, "Retired", Retired, v.e_ret);
    endtask

    function automatic vec_t mk(input logic rst, input logic rw, input logic m2r, input logic pcs,
                                input logic halt, input logic [15:0] alu, input logic [3:0] rd,
                                input logic [3:0] s1, input logic [3:0] s2);
        vec_t v;
        v = '{rst, rw, m2r, pcs, halt, alu, 16'h0000, 16'h0000, rd, s1, s2,
              16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000};
        return v;
    endfunction

    // Reference model: evaluates the rules directly on an array of registers
    function automatic logic [15:0] modelRead(input logic [3:0] a, input logic en,
                                              input logic [3:0] rd, input logic [15:0] wb);
        if (a == 4'd0) return 16'h0000;
        if (en && a == rd) return wb;
        return m_regs[a];
    endfunction

    task automatic modelPredict(inout vec_t v);
        v.e_wb     = v.pcs ? v.pcinc : (v.m2r ? v.dmem : v.alu);
        v.e_en     = v.rw && !m_halted && !v.halt && (v.rd != 4'd0);
        v.e_s1     = modelRead(v.s1, v.e_en, v.rd, v.e_wb);
        v.e_s2     = modelRead(v.s2, v.e_en, v.rd, v.e_wb);
        v.e_halted = m_halted;
        v.e_ret    = 16'(m_ret);
    endtask

    task automatic modelClock(input vec_t v);
        if (v.rst) begin
            for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
            m_halted = 1'b0;
            m_ret    = 0;
        end else begin
            if (v.e_en) m_regs[v.rd] = v.e_wb;
            if (!m_halted && (v.rw || v.m2r || v.pcs || v.halt)) m_ret = (m_ret + 1) % 65536;
            if (v.halt) m_halted = 1'b1;
        end
    endtask

    initial begin
        vec_t v;

        // rst rw m2r pcs halt | alu dmem pcinc | rd s1 s2 | e_s1 e_s2 e_wb e_en e_halted e_ret
        vecs[0]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 16'h1234,16'h0000,16'h0000, 4'd5,4'd5,4'd0,   16'h1234,16'h0000,16'h1234,1'b1,1'b0,16'd0};
        vecs[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 16'h0000,16'h0000,16'h0000, 4'd0,4'd5,4'd5,   16'h1234,16'h1234,16'h0000,1'b0,1'b0,16'd1};
        vecs[2]  = '{1'b0,1'b1,1'b1,1'b0,1'b0, 16'h0001,16'hBEEF,16'h0000, 4'd3,4'd3,4'd5,   16'hBEEF,16'h1234,16'hBEEF,1'b1,1'b0,16'd1};
        vecs[3]  = '{1'b0,1'b1,1'b1,1'b1,1'b0, 16'h0001,16'hBEEF,16'h0042, 4'd15,4'd3,4'd15, 16'hBEEF,16'h0042,16'h0042,1'b1,1'b0,16'd2};
        vecs[4]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 16'hFFFF,16'h0000,16'h0000, 4'd0,4'd15,4'd0,  16'h0042,16'h0000,16'hFFFF,1'b0,1'b0,16'd3};
        vecs[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 16'h0000,16'h0000,16'h0000, 4'd0,4'd0,4'd3,   16'h0000,16'hBEEF,16'h0000,1'b0,1'b0,16'd4};
        vecs[6]  = '{1'b0,1'b1,1'b0,1'b0,1'b1, 16'h5555,16'h0000,16'h0000, 4'd7,4'd7,4'd7,   16'h0000,16'h0000,16'h5555,1'b0,1'b0,16'd4};
        vecs[7]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 16'hAAAA,16'h0000,16'h0000, 4'd7,4'd7,4'd5,   16'h0000,16'h1234,16'hAAAA,1'b0,1'b1,16'd5};
        vecs[8]  = '{1'b0,1'b1,1'b0,1'b0,1'b1, 16'h1111,16'h0000,16'h0000, 4'd8,4'd8,4'd15,  16'h0000,16'h0042,16'h1111,1'b0,1'b1,16'd5};
        vecs[9]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, 16'h9999,16'h0000,16'h0000, 4'd9,4'd7,4'd3,   16'h0000,16'hBEEF,16'h9999,1'b0,1'b1,16'd5};
        vecs[10] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 16'h0000,16'h0000,16'h0000, 4'd0,4'd7,4'd3,   16'h0000,16'h0000,16'h0000,1'b0,1'b0,16'd0};
        vecs[11] = '{1'b0,1'b1,1'b0,1'b0,1'b0, 16'h7777,16'h0000,16'h0000, 4'd9,4'd9,4'd15,  16'h7777,16'h0000,16'h7777,1'b1,1'b0,16'd0};
        vecs[12] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 16'hABCD,16'h0000,16'h0000, 4'd10,4'd9,4'd10, 16'h7777,16'hABCD,16'hABCD,1'b1,1'b0,16'd1};
        vecs[13] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 16'h0000,16'h0000,16'h0000, 4'd0,4'd9,4'd10,  16'h0000,16'h0000,16'h0000,1'b0,1'b0,16'd0};

        $display("[TB] reset and register sweep");
        applyStimulus(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 4'd0, 4'd0));
        applyStimulus(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 4'd0, 4'd0));
        for (int i = 0; i < 8; i++) begin
            v = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 4'(2*i), 4'(2*i+1));
            applyStimulus(v);
            checkOutput(v, $sformatf("reset_r%0d", 2*i));
        end

        $display("[TB] directed table");
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], $sformatf("vec%0d", i));
        end

        $display("[TB] Retired wrap and reset-with-write");
        applyStimulus(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 4'd0, 4'd0));
        for (int i = 0; i < 65535; i++) begin
            applyStimulus(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'd0, 4'd0, 4'd0));
        end
        v = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1357, 4'd9, 4'd9, 4'd0);
        v.e_s1 = 16'h1357; v.e_wb = 16'h1357; v.e_en = 1'b1; v.e_ret = 16'hFFFF;
        applyStimulus(v);
        checkOutput(v, "wrap_pre");
        v = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h2468, 4'd9, 4'd9, 4'd0);
        v.e_s1 = 16'h2468; v.e_wb = 16'h2468; v.e_en = 1'b1; v.e_ret = 16'h0000;
        applyStimulus(v);
        checkOutput(v, "wrap_post");
        v = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 4'd9, 4'd9);
        applyStimulus(v);
        checkOutput(v, "rst_drops_r9");

        $display("[TB] randomized traffic");
        for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
        m_halted = 1'b0;
        m_ret    = 0;
        for (int i = 0; i < 2000; i++) begin
            v.rst   = ($urandom_range(0, 99) == 0);
            v.rw    = 1'($urandom_range(0, 1));
            v.m2r   = 1'($urandom_range(0, 1));
            v.pcs   = ($urandom_range(0, 3) == 0);
            v.halt  = ($urandom_range(0, 63) == 0);
            v.alu   = 16'($urandom);
            v.dmem  = 16'($urandom);
            v.pcinc = 16'($urandom);
            v.rd    = 4'($urandom);
            v.s1    = ($urandom_range(0, 2) == 0) ? v.rd : 4'($urandom);
            v.s2    = 4'($urandom);
            modelPredict(v);
            applyStimulus(v);
            checkOutput(v, $sformatf("rand%0d", i));
            modelClock(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback-stage consumer of the MEM/WB pipeline register outputs.
- Selects the writeback value (ALU result, load data or PC+2) and writes it into the 16x16 architectural register file.
- Provides two read ports to decode, with same-cycle write-to-read bypass.
- Tracks halt retirement and counts retired instructions for the testbench.

Parameters:
- NREG, 16, number of registers; index width is 4.
- DW, 16, data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-high; the name is kept per codebase port naming.
- RegWrite  in  1  writeback enable from MEM/WB.
- MemtoReg  in  1  select DataMem as writeback data.
- PCS  in  1  select PC_Inc as writeback data; has priority over MemtoReg.
- HALT  in  1  halt instruction retiring this cycle.
- ALU_Out  in  16  ALU result.
- DataMem  in  16  load data.
- PC_Inc  in  16  PC+2 of the retiring instruction.
- Rd  in  4  destination register.
- SrcReg1  in  4  read port 1 address.
- SrcReg2  in  4  read port 2 address.
- SrcData1  out  16  read port 1 data.
- SrcData2  out  16  read port 2 data.
- WB_Data  out  16  selected writeback value, combinational; also used by forwarding.
- WB_En  out  1  effective write enable (RegWrite & ~halted & Rd!=0).
- Halted  out  1  sticky; set after HALT retires.
- Retired  out  16  retired-instruction counter.

Behaviour:
- WB_Data selection:
  - PCS=1 -> PC_Inc.
  - else MemtoReg=1 -> DataMem.
  - else -> ALU_Out.
- Register file: 16 x 16-bit flops, written on rising clk when WB_En=1 at address Rd with WB_Data.
- R0 hardwired to 0x0000:
  - writes to R0 are discarded (WB_En=0).
  - reads of R0 return 0.
- Read ports are combinational:
  - SrcDataN = WB_Data if WB_En=1 and SrcRegN==Rd (bypass).
  - else SrcDataN = reg[SrcRegN].
  - Both ports may bypass in the same cycle.
- Halted:
  - cleared by reset.
  - set on the clock edge where HALT=1 and Halted=0.
  - holds until reset.
  - while Halted=1, all writes are suppressed and Retired freezes.
- A HALT instruction's own RegWrite is ignored; HALT suppresses its own write.
- Retired:
  - increments by 1 on each edge where Halted=0 and the cycle carries a valid instruction (RegWrite|MemtoReg|PCS|HALT).
  - the HALT cycle itself counts.
  - wraps 0xFFFF -> 0x0000 with no saturation.
  - bubbles (all controls 0) do not count.
- Reset (rst_n=1 at clk edge), including mid-operation:
  - all registers -> 0x0000, Halted=0, Retired=0.
  - any write presented that cycle is dropped.
  - outputs reflect reset state from the following cycle.
- Latency:
  - write is visible in the flops one edge after presentation.
  - bypass makes it visible to reads in the same cycle.
- No X propagation: all flops reset; unused combinational paths default to 0.

Test Plan:
- Reset, then read all 16 registers -> all 0x0000; Halted=0; Retired=0.
- RegWrite=1, MemtoReg=0, PCS=0, ALU_Out=0x1234, Rd=5, SrcReg1=5 -> SrcData1=0x1234 same cycle (bypass); next cycle with RegWrite=0, SrcReg1=5 -> 0x1234; Retired=1.
- Load then PCS write:
  - MemtoReg=1, DataMem=0xBEEF, ALU_Out=0x0001, Rd=3 -> R3=0xBEEF.
  - then PCS=1, MemtoReg=1, PC_Inc=0x0042, Rd=15 -> R15=0x0042 (PCS priority).
- RegWrite=1, Rd=0, ALU_Out=0xFFFF, SrcReg2=0 -> SrcData2=0x0000, WB_En=0; R0 remains 0.
- HALT=1 with RegWrite=1, Rd=7, ALU_Out=0x5555 -> R7 unchanged, Halted=1, Retired increments once; subsequent writes to R7 ignored and Retired frozen; then assert rst_n -> Halted=0, Retired=0, R7=0.
- Preload Retired to 0xFFFF with 65535 valid cycles, apply one more valid cycle -> Retired=0x0000; assert rst_n in the same cycle as a write to R9 -> R9=0x0000 afterwards.
